// File: rtl/aes128_job_scheduler_if.sv
// Requester job and response handshake bundle shared between the requesters/sink
// and aes128_job_scheduler.
interface aes128_job_scheduler_if #(
   parameter int unsigned ID_W = 4
);
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [127:0]    req0_key;
   logic [127:0]    req0_pt;
   logic [ID_W-1:0] req0_id;
   logic [127:0]    req1_key;
   logic [127:0]    req1_pt;
   logic [ID_W-1:0] req1_id;
   logic            resp_valid;
   logic            resp_ready;
   logic [127:0]    resp_data;
   logic            resp_src;
   logic [ID_W-1:0] resp_id;

   modport master (
      output req_valid, req0_key, req0_pt, req0_id, req1_key, req1_pt, req1_id, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_src, resp_id
   );

   modport slave (
      input  req_valid, req0_key, req0_pt, req0_id, req1_key, req1_pt, req1_id, resp_ready,
      output req_ready, resp_valid, resp_data, resp_src, resp_id
   );
endinterface

// File: rtl/aes128_job_scheduler.sv
// Round-robin sharing of one handshake-less AES-128 core between two requesters:
// accept a job, hold core inputs CORE_LATENCY cycles, return the cipher text with its tag.
module aes128_job_scheduler #(
   parameter int unsigned CORE_LATENCY = 12,
   parameter int unsigned ID_W         = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   aes128_job_scheduler_if.slave bus,
   output logic [127:0]          core_key,
   output logic [127:0]          core_pt,
   input  logic [127:0]          core_ct,
   output logic                  busy,
   output logic [15:0]           job_count
);

   localparam int unsigned CntW = $clog2(CORE_LATENCY + 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic            rr_last_q;
   logic [CntW-1:0] cnt_q;
   logic            resp_valid_q;
   logic [127:0]    resp_data_q;
   logic            resp_src_q;
   logic [ID_W-1:0] resp_id_q;
   logic [1:0]      req_ready;
   logic            grant;
   logic            accept;
   logic            resp_fire;

   // On a tie the requester that did not win last time gets the grant.
   assign grant     = (bus.req_valid == 2'b11) ? ~rr_last_q : bus.req_valid[1];
   assign accept    = (state_q == StIdle) && bus.req_valid[grant];
   assign resp_fire = (state_q == StResp) && resp_valid_q && bus.resp_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StWait;
         StWait:  if (cnt_q == '0) state_d = StResp;
         StResp:  if (resp_fire) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      busy      = (state_q != StIdle);
      if (state_q == StIdle) begin
         req_ready[grant] = bus.req_valid[grant];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_last_q    <= 1'b1;
         cnt_q        <= '0;
         core_key     <= '0;
         core_pt      <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_src_q   <= 1'b0;
         resp_id_q    <= '0;
         job_count    <= '0;
      end else begin
         if (accept) begin
            rr_last_q  <= grant;
            cnt_q      <= CntW'(CORE_LATENCY - 1);
            core_key   <= grant ? bus.req1_key : bus.req0_key;
            core_pt    <= grant ? bus.req1_pt : bus.req0_pt;
            resp_id_q  <= grant ? bus.req1_id : bus.req0_id;
            resp_src_q <= grant;
         end
         if (state_q == StWait) begin
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == '0) begin
               resp_data_q  <= core_ct;
               resp_valid_q <= 1'b1;
            end
         end
         if (resp_fire) begin
            resp_valid_q <= 1'b0;
            job_count    <= job_count + 16'd1;
         end
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_src   = resp_src_q;
   assign bus.resp_id    = resp_id_q;

endmodule

// File: tb/tb_aes128_job_scheduler.sv
// Self-checking bench for aes128_job_scheduler: XOR stand-in core, job scoreboard,
// directed scenarios followed by randomized job traffic.
module tb_aes128_job_scheduler;
   localparam int unsigned L  = 12;
   localparam int unsigned IW = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   aes128_job_scheduler_if #(.ID_W(IW)) bus ();
   logic [127:0] core_key, core_pt, core_ct;
   logic         busy;
   logic [15:0]  job_count;

   aes128_job_scheduler #(.CORE_LATENCY(L), .ID_W(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .core_key  (core_key),
      .core_pt   (core_pt),
      .core_ct   (core_ct),
      .busy      (busy),
      .job_count (job_count)
   );

   // Core stand-in: key^pt once inputs have been stable for L cycles, X before that.
   logic [127:0] m_key, m_pt;
   int unsigned  age = 0;
   always @(posedge clk) begin
      #1;
      if (core_key !== m_key || core_pt !== m_pt) begin
         m_key = core_key;
         m_pt  = core_pt;
         age   = 1;
      end else if (age < 1000) begin
         age = age + 1;
      end
   end
   assign core_ct = (age >= L) ? (m_key ^ m_pt) : 'x;

   logic [127:0]  key [2];
   logic [127:0]  pt  [2];
   logic [IW-1:0] id  [2];
   logic [1:0]    vld;
   logic          rdy;
   assign bus.req_valid  = vld;
   assign bus.req0_key   = key[0];
   assign bus.req0_pt    = pt[0];
   assign bus.req0_id    = id[0];
   assign bus.req1_key   = key[1];
   assign bus.req1_pt    = pt[1];
   assign bus.req1_id    = id[1];
   assign bus.resp_ready = rdy;

   typedef struct {
      logic          src;
      logic [IW-1:0] id;
      logic [127:0]  key;
      logic [127:0]  pt;
   } job_t;

   job_t        q[$];
   logic        last;
   logic [15:0] exp_count;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic new_data(input int r);
      key[r] = {$urandom, $urandom, $urandom, $urandom};
      pt[r]  = {$urandom, $urandom, $urandom, $urandom};
      id[r]  = IW'($urandom);
   endtask

   // Waits for a grant, checks the arbitration decision, records the job; returns after the edge.
   task automatic grant(output int g, output int gcyc);
      int   n;
      logic ge;
      job_t j;
      n = 0;
      #1;
      while (bus.req_ready == 2'b00 && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("grant_wait", 128'(n < 60), 128'(1));
      ge = (vld == 2'b11) ? ~last : vld[1];
      check("grant_sel", 128'(bus.req_ready), 128'(2'b01 << ge));
      check("grant_idle", 128'(busy), 128'(0));
      j.src = ge;
      j.id  = id[ge];
      j.key = key[ge];
      j.pt  = pt[ge];
      q.push_back(j);
      last = ge;
      g    = int'(ge);
      gcyc = cyc;
      @(posedge clk);
      #1;
   endtask

   // Follows the oldest job through WAIT and RESP; hold = cycles resp_ready stays low.
   task automatic finish_job(input int hold, input bit churn);
      job_t e;
      int   n;
      e = q.pop_front();
      rdy = (hold == 0);
      n = 0;
      while (n < L + 5) begin
         @(negedge clk);
         n++;
         if (bus.resp_valid) break;
         check("wait_core_key", core_key, e.key);
         check("wait_core_pt", core_pt, e.pt);
         check("wait_req_ready", 128'(bus.req_ready), 128'(0));
         if (churn && n == 4) new_data(e.src ? 0 : 1);
      end
      check("resp_latency", 128'(n), 128'(L + 1));
      check("resp_data", bus.resp_data, e.key ^ e.pt);
      check("resp_src", 128'(bus.resp_src), 128'(e.src));
      check("resp_id", 128'(bus.resp_id), 128'(e.id));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", 128'(bus.resp_valid), 128'(1));
         check("hold_data", bus.resp_data, e.key ^ e.pt);
         check("hold_src", 128'(bus.resp_src), 128'(e.src));
         check("hold_id", 128'(bus.resp_id), 128'(e.id));
         check("hold_req_ready", 128'(bus.req_ready), 128'(0));
      end
      rdy = 1'b1;
      check("accept_req_ready", 128'(bus.req_ready), 128'(0));
      @(negedge clk);
      exp_count = exp_count + 16'd1;
      check("post_valid", 128'(bus.resp_valid), 128'(0));
      check("job_count", 128'(job_count), 128'(exp_count));
      check("post_busy", 128'(busy), 128'(0));
   endtask

   initial begin
      int g, gc, prev;
      vld = 2'b00;
      rdy = 1'b0;
      new_data(0);
      new_data(1);
      last = 1'b1;
      exp_count = '0;

      // Reset values
      #3;
      check("rst_core_key", core_key, 128'(0));
      check("rst_core_pt", core_pt, 128'(0));
      check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
      check("rst_resp_data", bus.resp_data, 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_job_count", 128'(job_count), 128'(0));
      check("rst_req_ready", 128'(bus.req_ready), 128'(0));
      @(negedge clk);
      reset = 1'b1;

      // Single job from requester 0
      key[0] = 128'h0F0E0D0C0B0A09080706050403020100;
      pt[0]  = 128'hFFEEDDCCBBAA99887766554433221100;
      id[0]  = 4'd3;
      vld    = 2'b01;
      grant(g, gc);
      vld = 2'b00;
      finish_job(0, 0);

      // Both requesters continuously valid: alternating grants at full rate
      new_data(0);
      new_data(1);
      vld = 2'b11;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         grant(g, gc);
         if (k > 0) check("grant_space", 128'(gc - prev), 128'(L + 2));
         prev = gc;
         new_data(g);
         finish_job(0, 0);
      end

      // Response back-pressure for 5 cycles
      grant(g, gc);
      prev = gc;
      new_data(g);
      finish_job(5, 0);
      grant(g, gc);
      check("grant_space_bp", 128'(gc - prev), 128'(L + 2 + 5));
      new_data(g);
      finish_job(0, 0);

      // Other requester changes its data while a job waits on the core
      grant(g, gc);
      new_data(g);
      finish_job(0, 1);
      grant(g, gc);
      new_data(g);
      finish_job(0, 0);

      // Reset during WAIT discards the job
      grant(g, gc);
      new_data(g);
      repeat (4) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_core_key", core_key, 128'(0));
      check("mid_rst_core_pt", core_pt, 128'(0));
      check("mid_rst_resp_valid", 128'(bus.resp_valid), 128'(0));
      check("mid_rst_busy", 128'(busy), 128'(0));
      check("mid_rst_job_count", 128'(job_count), 128'(0));
      q.delete();
      last = 1'b1;
      exp_count = '0;
      vld = 2'b00;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < L + 4; k++) begin
         @(negedge clk);
         check("post_rst_no_resp", 128'(bus.resp_valid), 128'(0));
      end
      new_data(0);
      new_data(1);
      vld = 2'b11;
      grant(g, gc);
      check("post_rst_tie_winner", 128'(g), 128'(0));
      new_data(g);
      finish_job(0, 0);

      // Randomized traffic
      for (int j = 0; j < 24; j++) begin
         logic [1:0] nv;
         nv = 2'($urandom_range(1, 3));
         for (int r = 0; r < 2; r++) if (!vld[r]) new_data(r);
         vld = nv;
         grant(g, gc);
         new_data(g);
         finish_job(int'($urandom_range(0, 3)), 0);
      end

      vld = 2'b00;
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
